// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, Funct3 encodings and formatting helpers for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Transaction sequencing: wait for an instruction, run the bus
    // handshake, then report the outcome for one cycle.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Move the addressed byte/half down to bit 0 and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [31:0] word,
                                                input logic [1:0]  off);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_BU:   r = {24'h000000, s[7:0]};
            F3_HU:   r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Misaligned halves/words, unsigned stores and unused encodings are
    // rejected before any bus activity.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = |off;
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Data-memory req/ack port between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational store lane formatting and load extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wr_data,
    input  logic [31:0] i_mem_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    // Replicate the store operand so every enabled lane carries it.
    always_comb begin
        o_be        = store_be(i_funct3, i_addr_lo);
        o_load_data = load_extend(i_funct3, i_mem_rdata, i_addr_lo);
        case (i_funct3)
            F3_B:    o_wdata = {4{i_wr_data[7:0]}};
            F3_H:    o_wdata = {2{i_wr_data[15:0]}};
            default: o_wdata = i_wr_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Memory-stage load/store unit: req/ack bus sequencing, store
//               formatting, load alignment and pipeline stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  done,
    output logic                  fault,
    output logic                  stall,
    lsu_if.master                 mem
);

    lsu_state_t            r_state;
    lsu_state_t            w_state_nxt;

    logic [DATA_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic                  r_fault;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_idle;
    logic                  w_go;
    logic                  w_bad;
    logic [2:0]            w_funct3;
    logic [1:0]            w_addr_lo;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_load;

    assign w_idle = (r_state == S_IDLE);
    assign w_go   = w_idle & start & (MemRead | MemWrite);
    assign w_bad  = access_fault(MemWrite, Funct3, Addr[1:0]);

    // In IDLE the aligner formats the incoming store; afterwards it decodes
    // the returning read word with the latched size and offset.
    assign w_funct3  = w_idle ? Funct3    : r_funct3;
    assign w_addr_lo = w_idle ? Addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_funct3    (w_funct3),
        .i_addr_lo   (w_addr_lo),
        .i_wr_data   (WrData),
        .i_mem_rdata (mem.mem_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_load_data (w_load)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state: faults skip the bus and report straight away.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_state_nxt = w_bad ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem.mem_ack) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture at acceptance and load-result capture at ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_fault   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_go) begin
                r_fault <= w_bad;
                if (!w_bad) begin
                    r_addr    <= {Addr[DATA_WIDTH-1:2], 2'b00};
                    r_we      <= MemWrite;
                    r_be      <= MemWrite ? w_be : 4'b1111;
                    r_wdata   <= MemWrite ? w_wdata : '0;
                    r_funct3  <= Funct3;
                    r_addr_lo <= Addr[1:0];
                end
            end
            if ((r_state == S_ACCESS) && mem.mem_ack && !r_we)
                r_rd_data <= w_load;
        end
    end

    assign mem.mem_req   = (r_state == S_ACCESS);
    assign mem.mem_we    = r_we & (r_state == S_ACCESS);
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;

    assign RdData = r_rd_data;
    assign done   = (r_state == S_RESP) & ~r_fault;
    assign fault  = (r_state == S_RESP) &  r_fault;
    assign stall  = w_go | (r_state == S_ACCESS);

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu with a behavioural memory-access
//               reference model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        done;
    logic        fault;
    logic        stall;

    lsu_if #(.DATA_WIDTH(32)) mem_bus ();

    lsu #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Funct3   (Funct3),
        .Addr     (Addr),
        .WrData   (WrData),
        .RdData   (RdData),
        .done     (done),
        .fault    (fault),
        .stall    (stall),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    logic [31:0] exp_rd;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 1;
        endcase
    endfunction

    function automatic bit ref_fault(input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        bit legal;
        case (f3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = !wr;
            default:          legal = 1'b0;
        endcase
        return !legal || ((a % ref_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] ref_be(input bit wr, input logic [2:0] f3,
                                           input logic [31:0] a);
        int sz;
        if (!wr) return 32'hF;
        sz = ref_size(f3);
        return (((1 << sz) - 1) << (a % 4)) & 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                              input logic [31:0] d);
        case (ref_size(f3))
            1:       return (d & 32'hFF) * 32'h01010101;
            2:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // One full transaction; ack arrives dly cycles after the first ACCESS
    // cycle. With hold set, start stays high while the access is in flight.
    task automatic run_op(input bit wr, input bit rd, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int dly, input logic [31:0] word,
                          input bit hold);
        bit flt;
        int done0;
        flt   = ref_fault(wr, f3, a);
        done0 = n_done;
        step();
        start = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        Addr = a; WrData = d;
        @(negedge clk);
        check("stall_start", {31'd0, stall}, {31'd0, rd | wr});
        check("done_idle", {31'd0, done}, 32'd0);
        step();
        if (!hold || flt) start = 1'b0;
        Addr = $urandom; WrData = $urandom; Funct3 = 3'($urandom);
        if (!(rd | wr)) begin
            @(negedge clk);
            check("noop_req", {31'd0, mem_bus.mem_req}, 32'd0);
            check("noop_done", {31'd0, done | fault}, 32'd0);
            return;
        end
        if (flt) begin
            @(negedge clk);
            check("fault_pulse", {31'd0, fault}, 32'd1);
            check("fault_nodone", {31'd0, done}, 32'd0);
            check("fault_req", {31'd0, mem_bus.mem_req}, 32'd0);
            check("fault_stall", {31'd0, stall}, 32'd0);
            check("fault_rd", RdData, exp_rd);
            step();
            @(negedge clk);
            check("fault_once", {31'd0, fault}, 32'd0);
            return;
        end
        for (int i = 0; i <= dly; i++) begin
            if (i == dly) begin
                mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = word; start = 1'b0;
            end else begin
                mem_bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            check("req", {31'd0, mem_bus.mem_req}, 32'd1);
            check("addr", mem_bus.mem_addr, a & 32'hFFFFFFFC);
            check("be", {28'd0, mem_bus.mem_be}, ref_be(wr, f3, a));
            check("we", {31'd0, mem_bus.mem_we}, {31'd0, wr});
            if (wr) check("wdata", mem_bus.mem_wdata, ref_wdata(f3, d));
            check("stall_acc", {31'd0, stall}, 32'd1);
            check("done_acc", {31'd0, done}, 32'd0);
            step();
            mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom;
        end
        if (!wr) exp_rd = ref_load(f3, a, word);
        @(negedge clk);
        check("done", {31'd0, done}, 32'd1);
        check("nofault", {31'd0, fault}, 32'd0);
        check("req_fall", {31'd0, mem_bus.mem_req}, 32'd0);
        check("stall_resp", {31'd0, stall}, 32'd0);
        check("rddata", RdData, exp_rd);
        step();
        @(negedge clk);
        check("done_once", {31'd0, done}, 32'd0);
        check("one_done", n_done - done0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = 3'd0; Addr = '0; WrData = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        exp_rd = '0;
        #3;
        check("rst_rd", RdData, 32'd0);
        check("rst_flags", {29'd0, done, fault, mem_bus.mem_req}, 32'd0);
        check("rst_bus", {27'd0, mem_bus.mem_we, mem_bus.mem_be}, 32'd0);
        check("rst_addr", mem_bus.mem_addr, 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        step();
        reset_n = 1'b1;

        // Directed cases.
        run_op(1, 0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0);
        run_op(1, 0, 3'd0, 32'h103, 32'h000000A5, 1, 32'h0, 0);
        run_op(0, 1, 3'd0, 32'h102, 32'h0, 2, 32'h12F45678, 0);
        check("lb_lit", RdData, 32'hFFFFFFF4);
        run_op(0, 1, 3'd4, 32'h102, 32'h0, 2, 32'h12F45678, 0);
        check("lbu_lit", RdData, 32'h000000F4);
        run_op(0, 1, 3'd1, 32'h101, 32'h0, 0, 32'h0, 0);
        run_op(0, 1, 3'd2, 32'h102, 32'h0, 0, 32'h0, 0);
        run_op(1, 0, 3'd4, 32'h100, 32'h11223344, 0, 32'h0, 0);
        check("fault_keep_rd", RdData, 32'h000000F4);
        run_op(1, 1, 3'd1, 32'h202, 32'hCAFE1234, 1, 32'h0, 0);
        run_op(0, 1, 3'd5, 32'h302, 32'h0, 0, 32'h8001ABCD, 0);
        run_op(1, 0, 3'd2, 32'h400, 32'h0BADF00D, 3, 32'h0, 1);
        run_op(0, 0, 3'd2, 32'h500, 32'h0, 0, 32'h0, 0);

        // Reset while an access is outstanding.
        begin
            int done0;
            done0 = n_done;
            step();
            start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2;
            Addr = 32'h600;
            step();
            start = 1'b0;
            @(negedge clk);
            check("rst_mid_req_before", {31'd0, mem_bus.mem_req}, 32'd1);
            #2 reset_n = 1'b0;
            #1;
            check("rst_mid_req", {31'd0, mem_bus.mem_req}, 32'd0);
            check("rst_mid_stall", {31'd0, stall}, 32'd0);
            check("rst_mid_rd", RdData, 32'd0);
            exp_rd = '0;
            step();
            mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h55555555;
            step();
            mem_bus.mem_ack = 1'b0;
            reset_n = 1'b1;
            @(negedge clk);
            check("rst_mid_idle", {30'd0, mem_bus.mem_req, done}, 32'd0);
            check("rst_mid_nodone", n_done - done0, 32'd0);
            check("rst_mid_rd_kept", RdData, 32'd0);
            run_op(0, 1, 3'd2, 32'h604, 32'h0, 1, 32'h76543210, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            bit          wr, rd, hold;
            logic [2:0]  f3;
            int          pick;
            wr   = 1'($urandom);
            rd   = ($urandom_range(0, 7) != 0) ? !wr : 1'b0;
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1:    f3 = 3'd0;
                2, 3:    f3 = 3'd1;
                4, 5:    f3 = 3'd2;
                6:       f3 = 3'd4;
                7:       f3 = 3'd5;
                default: f3 = 3'($urandom);
            endcase
            hold = ($urandom_range(0, 3) == 0);
            run_op(wr, rd, f3, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom, hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
# lsu

Load/store unit for the RISC-V core's memory stage, directly downstream of the ALU. It takes the ALU result as the effective address, plus the store data and funct3 for the memory instruction, and runs a req/ack transaction on the data-memory port. It formats byte enables and write data for stores, and aligns and sign- or zero-extends load data. While the access is in flight it holds the pipeline stalled.

## Interface
- DATA_WIDTH, 32: data and address width; only 32 is supported.
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  memory instruction present in this stage; sampled only in IDLE.
- MemRead  in  1  instruction is a load.
- MemWrite  in  1  instruction is a store; wins if both read and write are set.
- Funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000, 001 and 010.
- Addr  in  32  effective address (ALUResult).
- WrData  in  32  rs2 value to store.
- RdData  out  32  formatted load result; holds until the next load completes.
- done  out  1  one-cycle pulse when the access finishes.
- fault  out  1  one-cycle pulse for a misaligned access or illegal Funct3; no memory access is made.
- stall  out  1  pipeline hold.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  32  word-aligned address: Addr[31:2] followed by 2'b00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  replicated store data.
- mem_ack  in  1  memory accepts the request; for reads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE: start is qualified only when MemRead or MemWrite is set; anything else is a no-op.
  - Fault check: H/HU with Addr[0]=1, W with Addr[1:0]≠0, or Funct3 outside the set allowed for the operation.
  - On a fault, go to RESP with fault pending.
  - Otherwise latch the request (address, be, wdata, we, Funct3, Addr[1:0]) and go to ACCESS.
- ACCESS: mem_req=1. All mem_* outputs stay stable until mem_ack. On mem_ack, go to RESP; for a load, latch the formatted mem_rdata into RdData on the same edge.
- RESP: pulse done, or fault for a faulting request. Return to IDLE.
- start seen in ACCESS or RESP is ignored; the pipeline holds it via stall.
- Store formatting:
  - SB: be = 4'b0001 shifted left by Addr[1:0]; wdata is the byte replicated 4 times.
  - SH: be = 4'b0011 shifted left by 2·Addr[1]; wdata is the half replicated twice.
  - SW: be = 4'b1111; wdata = WrData.
- Load formatting: shift mem_rdata right by 8·Addr[1:0], then take the low byte or half. B/H sign-extend, BU/HU zero-extend, W passes through.
- Reads drive mem_be = 4'b1111 and mem_we = 0.
- Stores and faults leave RdData unchanged.

## Timing
- Reset values: state IDLE; RdData, done, fault, mem_req, mem_we, mem_addr, mem_be and mem_wdata all 0.
- stall = start & (MemRead | MemWrite) & IDLE, OR state is ACCESS, OR state is RESP with done/fault not yet shown. Net effect: stall is high from the start cycle through the cycle before done/fault. stall is combinational from the start input.
- Latency: start in cycle 0 makes mem_req high in cycle 1. mem_ack in cycle k (k≥1) makes done and valid RdData appear in cycle k+1. The minimum is 2 cycles.
- Fault path: start in cycle 0 gives fault in cycle 1, and stall drops in cycle 1.
- mem_req falls in the cycle after mem_ack. Back-to-back: a new start is accepted in the cycle after RESP.
- Reset mid-operation: every output clears asynchronously, mem_req drops immediately, no done is issued, and the in-flight access is abandoned.
- mem_ack while not in ACCESS is ignored.

## Structure
- lsu_pkg holds:
  - the state enum;
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - functions for store byte enables and load extension.
- lsu_align is a combinational sub-module. Inputs: Funct3, Addr[1:0], WrData, mem_rdata. Outputs: be, wdata, load result.
- The top level holds the FSM and the registers.

## Test plan
- SW to 0x100 with data 0xDEADBEEF and ack in the first ACCESS cycle: mem_addr=0x100, be=1111, wdata=0xDEADBEEF, mem_we=1; done in cycle 2; stall is high for cycles 0-1.
- SB to 0x103 with WrData=0x000000A5: be=1000, wdata=0xA5A5A5A5.
- LB from 0x102 with mem_rdata=0x12F45678 and ack delayed 3 cycles: mem_* stay stable; RdData=0xFFFFFFF4 and done in cycle 4.
  - LBU under the same conditions gives RdData=0x000000F4.
- LH from 0x101: fault in cycle 1, mem_req never rises, RdData is unchanged.
  - LW from 0x102 faults the same way.
  - A store with Funct3=100 faults the same way.
- reset_n asserted low during ACCESS: mem_req goes to 0 immediately; after release the FSM is in IDLE, no done is issued, and a new LW completes normally.
- start asserted again while in ACCESS: ignored; exactly one transaction and one done.
